// File: rtl/ili9488_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ili9488_bus_decoder
// Description : Display-side decoder for the 8-bit ILI9488 write bus.
//               Decodes command/parameter bytes, tracks the CASET/PASET
//               address window and assembles RGB565 pixels from RAMWR data,
//               reporting each pixel with its x/y position plus a
//               frame-completion pulse on the last pixel of the window.
// Ports       : clk, rst_n (async, active low)
//               data_in[7:0], send_data, data_command, disp_cs : bus input
//               cmd_valid, cmd_byte[7:0]                       : command out
//               col_start/col_end/page_start/page_end[8:0]     : window
//               pixel_valid, pixel_data[15:0], pixel_x/y[8:0]  : pixels
//               frame_done, proto_err (sticky)                 : status
// Revision    : 1.0 - initial release
// ============================================================================
module ili9488_bus_decoder #(
  parameter int H_RES = 320,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        send_data,
  input  logic        data_command,
  input  logic        disp_cs,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic [8:0]  col_start,
  output logic [8:0]  col_end,
  output logic [8:0]  page_start,
  output logic [8:0]  page_end,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        frame_done,
  output logic        proto_err
);

  localparam logic [8:0]  c_col_last = 9'(H_RES - 1);
  localparam logic [8:0]  c_page_last = 9'(V_RES - 1);
  localparam logic [15:0] c_col_lim = 16'(H_RES);
  localparam logic [15:0] c_page_lim = 16'(V_RES);

  localparam logic [7:0] c_cmd_caset = 8'h2A;
  localparam logic [7:0] c_cmd_paset = 8'h2B;
  localparam logic [7:0] c_cmd_ramwr = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_PASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_OTHER = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_arg_cnt;     // parameter bytes received for CASET/PASET
  logic [15:0] r_sh_start;    // shadow start (SH,SL)
  logic [7:0]  r_sh_end_hi;   // shadow end high byte (EH)
  logic        r_half_valid;  // high byte of a pixel is pending
  logic [7:0]  r_half;
  // Window snapshot taken at 0x2C; later CASET/PASET do not disturb an
  // ongoing memory write.
  logic [8:0]  r_aw_xs, r_aw_xe, r_aw_ys, r_aw_ye;
  logic [8:0]  r_cur_x, r_cur_y;

  logic [15:0] w_arg_end;
  logic [15:0] w_arg_lim;
  logic        w_arg_ok;
  logic        w_x_last;
  logic        w_y_last;

  always_comb begin
    w_arg_end = {r_sh_end_hi, data_in};
    w_arg_lim = (r_state == ST_CASET) ? c_col_lim : c_page_lim;
    w_arg_ok  = (r_sh_start <= w_arg_end) && (w_arg_end < w_arg_lim);
    w_x_last  = (r_cur_x == r_aw_xe);
    w_y_last  = (r_cur_y == r_aw_ye);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_arg_cnt    <= 2'd0;
      r_sh_start   <= 16'd0;
      r_sh_end_hi  <= 8'd0;
      r_half_valid <= 1'b0;
      r_half       <= 8'd0;
      r_aw_xs      <= 9'd0;
      r_aw_xe      <= c_col_last;
      r_aw_ys      <= 9'd0;
      r_aw_ye      <= c_page_last;
      r_cur_x      <= 9'd0;
      r_cur_y      <= 9'd0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'd0;
      col_start    <= 9'd0;
      col_end      <= c_col_last;
      page_start   <= 9'd0;
      page_end     <= c_page_last;
      pixel_valid  <= 1'b0;
      pixel_data   <= 16'd0;
      pixel_x      <= 9'd0;
      pixel_y      <= 9'd0;
      frame_done   <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (disp_cs) begin
        // Deselect abandons partial transfers silently; state is kept so a
        // memory write resumes once the panel is selected again.
        r_half_valid <= 1'b0;
        r_arg_cnt    <= 2'd0;
      end else if (send_data) begin
        if (!data_command) begin
          cmd_byte     <= data_in;
          cmd_valid    <= 1'b1;
          r_arg_cnt    <= 2'd0;
          r_half_valid <= 1'b0;
          if ((r_state == ST_CASET) || (r_state == ST_PASET) || r_half_valid)
            proto_err <= 1'b1;
          case (data_in)
            c_cmd_caset: r_state <= ST_CASET;
            c_cmd_paset: r_state <= ST_PASET;
            c_cmd_ramwr: begin
              r_state <= ST_RAMWR;
              r_aw_xs <= col_start;
              r_aw_xe <= col_end;
              r_aw_ys <= page_start;
              r_aw_ye <= page_end;
              r_cur_x <= col_start;
              r_cur_y <= page_start;
            end
            default:     r_state <= ST_OTHER;
          endcase
        end else begin
          case (r_state)
            ST_CASET, ST_PASET: begin
              r_arg_cnt <= r_arg_cnt + 2'd1;
              case (r_arg_cnt)
                2'd0: r_sh_start[15:8] <= data_in;
                2'd1: r_sh_start[7:0]  <= data_in;
                2'd2: r_sh_end_hi      <= data_in;
                default: begin
                  r_state <= ST_OTHER;
                  if (!w_arg_ok) begin
                    proto_err <= 1'b1;
                  end else if (r_state == ST_CASET) begin
                    col_start <= r_sh_start[8:0];
                    col_end   <= w_arg_end[8:0];
                  end else begin
                    page_start <= r_sh_start[8:0];
                    page_end   <= w_arg_end[8:0];
                  end
                end
              endcase
            end
            ST_RAMWR: begin
              if (!r_half_valid) begin
                r_half       <= data_in;
                r_half_valid <= 1'b1;
              end else begin
                r_half_valid <= 1'b0;
                pixel_valid  <= 1'b1;
                pixel_data   <= {r_half, data_in};
                pixel_x      <= r_cur_x;
                pixel_y      <= r_cur_y;
                frame_done   <= w_x_last && w_y_last;
                // Raster order inside the window, wrapping back to the
                // top-left corner after the last pixel.
                if (w_x_last) begin
                  r_cur_x <= r_aw_xs;
                  r_cur_y <= w_y_last ? r_aw_ys : (r_cur_y + 9'd1);
                end else begin
                  r_cur_x <= r_cur_x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ili9488_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ili9488_bus_decoder
// Description : Self-checking bench for ili9488_bus_decoder. A byte-level
//               model tracks window, argument and pixel bookkeeping with
//               queues and a linear pixel index; every cycle the DUT outputs
//               are compared against it, and literal expectations pin the
//               model on the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ili9488_bus_decoder;

  // Scaled-down panel so a full-window fill stays short.
  localparam int H = 24;
  localparam int V = 16;

  localparam int M_IDLE  = 0;
  localparam int M_CASET = 1;
  localparam int M_PASET = 2;
  localparam int M_RAMWR = 3;
  localparam int M_OTHER = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        send_data = 1'b0;
  logic        data_command = 1'b0;
  logic        disp_cs = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [8:0]  col_start, col_end, page_start, page_end;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [8:0]  pixel_x, pixel_y;
  logic        frame_done;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  // model state
  int  m_mode;
  int  args[$];
  int  half_q[$];
  int  w_cs, w_ce, w_ps, w_pe;
  int  aw_xs, aw_xe, aw_ys, aw_ye;
  int  m_n;
  int  e_cmd;
  bit  e_cmdv, e_pv, e_fd, e_err;
  int  e_pd, e_px, e_py;

  int  pv_cnt, fd_cnt, fd_x, fd_y;

  always #5 clk = ~clk;

  ili9488_bus_decoder #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .send_data(send_data),
    .data_command(data_command), .disp_cs(disp_cs),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .col_start(col_start), .col_end(col_end),
    .page_start(page_start), .page_end(page_end),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  task automatic model_reset();
    m_mode = M_IDLE;
    args.delete();
    half_q.delete();
    w_cs = 0; w_ce = H - 1; w_ps = 0; w_pe = V - 1;
    aw_xs = 0; aw_xe = H - 1; aw_ys = 0; aw_ye = V - 1;
    m_n = 0;
    e_cmd = 0; e_cmdv = 0; e_pv = 0; e_fd = 0; e_err = 0;
    e_pd = 0; e_px = 0; e_py = 0;
  endtask

  task automatic model_step(bit sd, bit dc, bit cs, logic [7:0] b);
    int s, e, lim, w, h;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_cmdv = 0; e_pv = 0; e_fd = 0;
    if (cs) begin
      args.delete();
      half_q.delete();
    end else if (sd) begin
      if (!dc) begin
        if (m_mode == M_CASET || m_mode == M_PASET || half_q.size() != 0) e_err = 1;
        args.delete();
        half_q.delete();
        e_cmd = int'(b);
        e_cmdv = 1;
        case (b)
          8'h2A: m_mode = M_CASET;
          8'h2B: m_mode = M_PASET;
          8'h2C: begin
            m_mode = M_RAMWR;
            aw_xs = w_cs; aw_xe = w_ce; aw_ys = w_ps; aw_ye = w_pe;
            m_n = 0;
          end
          default: m_mode = M_OTHER;
        endcase
      end else if (m_mode == M_CASET || m_mode == M_PASET) begin
        args.push_back(int'(b));
        if (args.size() == 4) begin
          s = args[0] * 256 + args[1];
          e = args[2] * 256 + args[3];
          lim = (m_mode == M_CASET) ? H : V;
          if (s <= e && e < lim) begin
            if (m_mode == M_CASET) begin w_cs = s; w_ce = e; end
            else begin w_ps = s; w_pe = e; end
          end else begin
            e_err = 1;
          end
          args.delete();
          m_mode = M_OTHER;
        end
      end else if (m_mode == M_RAMWR) begin
        if (half_q.size() == 0) begin
          half_q.push_back(int'(b));
        end else begin
          w = aw_xe - aw_xs + 1;
          h = aw_ye - aw_ys + 1;
          e_pv = 1;
          e_pd = half_q[0] * 256 + int'(b);
          e_px = aw_xs + (m_n % w);
          e_py = aw_ys + (m_n / w);
          e_fd = (m_n == w * h - 1);
          m_n = (m_n + 1) % (w * h);
          half_q.delete();
        end
      end
    end
  endtask

  task automatic compare();
    bit bad;
    bad = (cmd_valid != e_cmdv) || (int'(cmd_byte) != e_cmd) ||
          (int'(col_start) != w_cs) || (int'(col_end) != w_ce) ||
          (int'(page_start) != w_ps) || (int'(page_end) != w_pe) ||
          (pixel_valid != e_pv) || (int'(pixel_data) != e_pd) ||
          (int'(pixel_x) != e_px) || (int'(pixel_y) != e_py) ||
          (frame_done != e_fd) || (proto_err != e_err);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got cv=%0d cmd=%h win=%0d..%0d/%0d..%0d pv=%0d pd=%h xy=%0d,%0d fd=%0d err=%0d exp cv=%0d cmd=%h win=%0d..%0d/%0d..%0d pv=%0d pd=%h xy=%0d,%0d fd=%0d err=%0d",
               $time, cmd_valid, cmd_byte, col_start, col_end, page_start, page_end,
               pixel_valid, pixel_data, pixel_x, pixel_y, frame_done, proto_err,
               e_cmdv, e_cmd[7:0], w_cs, w_ce, w_ps, w_pe, e_pv, e_pd[15:0], e_px, e_py, e_fd, e_err);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One bus cycle: inputs applied at a falling edge, model advanced at the
  // rising edge, outputs compared at the next falling edge.
  task automatic drive(bit sd, bit dc, bit cs, logic [7:0] b);
    send_data = sd; data_command = dc; disp_cs = cs; data_in = b;
    @(posedge clk);
    model_step(sd, dc, cs, b);
    @(negedge clk);
    compare();
    pv_cnt += int'(pixel_valid);
    if (frame_done) begin
      fd_cnt++; fd_x = int'(pixel_x); fd_y = int'(pixel_y);
    end
    send_data = 1'b0; disp_cs = 1'b0;
  endtask

  task automatic cmd(logic [7:0] b);  drive(1'b1, 1'b0, 1'b0, b); endtask
  task automatic dat(logic [7:0] b);  drive(1'b1, 1'b1, 1'b0, b); endtask
  task automatic idle();              drive(1'b0, 1'b1, 1'b0, 8'h00); endtask

  task automatic set4(logic [7:0] c, logic [7:0] a0, logic [7:0] a1,
                      logic [7:0] a2, logic [7:0] a3);
    cmd(c); dat(a0); dat(a1); dat(a2); dat(a3);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    repeat (3) idle();
    rst_n = 1'b1;
    idle();

    // reset state
    chk("rst_cmd_byte", int'(cmd_byte), 0);
    chk("rst_col_end", int'(col_end), H - 1);
    chk("rst_page_end", int'(page_end), V - 1);
    chk("rst_proto_err", int'(proto_err), 0);

    // first pixel at origin
    cmd(8'h2C);
    chk("t1_cmd_valid", int'(cmd_valid), 1);
    dat(8'hF8);
    chk("t1_no_half_pixel", int'(pixel_valid), 0);
    dat(8'h00);
    chk("t1_pv", int'(pixel_valid), 1);
    chk("t1_pd", int'(pixel_data), 16'hF800);
    chk("t1_xy", int'(pixel_x) * 1000 + int'(pixel_y), 0);
    idle();
    chk("t1_pv_pulse", int'(pixel_valid), 0);

    // 2x1 window, two wraps
    set4(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B);
    set4(8'h2B, 8'h00, 8'h05, 8'h00, 8'h05);
    chk("t2_col_start", int'(col_start), 10);
    chk("t2_page_end", int'(page_end), 5);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) begin
      dat(8'h12);
      dat(8'h34);
      chk("t2_px", int'(pixel_x), (i % 2 == 0) ? 10 : 11);
      chk("t2_py", int'(pixel_y), 5);
      chk("t2_fd", int'(frame_done), i % 2);
    end

    // full-panel fill
    set4(8'h2A, 8'h00, 8'h00, 8'h00, 8'(H - 1));
    set4(8'h2B, 8'h00, 8'h00, 8'h00, 8'(V - 1));
    cmd(8'h2C);
    pv_cnt = 0; fd_cnt = 0; fd_x = -1; fd_y = -1;
    for (int i = 0; i < H * V; i++) begin
      dat(8'hF8);
      dat(8'h00);
    end
    chk("fill_pixels", pv_cnt, H * V);
    chk("fill_frames", fd_cnt, 1);
    chk("fill_fd_x", fd_x, H - 1);
    chk("fill_fd_y", fd_y, V - 1);
    chk("fill_err", int'(proto_err), 0);

    // deselect between the two halves of a pixel
    cmd(8'h2C);
    dat(8'hF8);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 8'h55);
    pv_cnt = 0;
    dat(8'h07);
    chk("cs_no_pixel_yet", int'(pixel_valid), 0);
    dat(8'hE0);
    chk("cs_pd", int'(pixel_data), 16'h07E0);
    chk("cs_pixels", pv_cnt, 1);
    chk("cs_err", int'(proto_err), 0);

    // rejected windows
    set4(8'h2A, 8'h01, 8'h00, 8'h00, 8'h10);
    chk("bad_order_err", int'(proto_err), 1);
    chk("bad_order_cs", int'(col_start), 0);
    chk("bad_order_ce", int'(col_end), H - 1);
    set4(8'h2A, 8'h01, 8'h40, 8'h01, 8'h40);
    set4(8'h2A, 8'h00, 8'h00, 8'h00, 8'(H));
    chk("bad_end_ce", int'(col_end), H - 1);
    set4(8'h2A, 8'h00, 8'h02, 8'h00, 8'(H - 1));
    chk("edge_end_cs", int'(col_start), 2);

    // deselect mid-argument restarts the argument sequence
    cmd(8'h2A); dat(8'h00); dat(8'h03);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    dat(8'h00); dat(8'h04); dat(8'h00); dat(8'h05);
    chk("cs_arg_cs", int'(col_start), 4);
    chk("cs_arg_ce", int'(col_end), 5);

    // asynchronous reset mid-pixel
    cmd(8'h2C);
    dat(8'hF8);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_err", int'(proto_err), 0);
    chk("arst_ce", int'(col_end), H - 1);
    chk("arst_cmd", int'(cmd_byte), 0);
    chk("arst_pd", int'(pixel_data), 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    idle();

    // command while half a pixel is pending
    cmd(8'h2C);
    dat(8'hF8);
    cmd(8'h00);
    chk("half_cmd_valid", int'(cmd_valid), 1);
    chk("half_cmd_byte", int'(cmd_byte), 0);
    chk("half_pv", int'(pixel_valid), 0);
    chk("half_err", int'(proto_err), 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
